fifo_drain_vs: RTL and testbench

- Read-side adapter for the show-ahead FIFO interface (empty / data / rdreq) used at the output of the L-shaped side-band buffers.
- Drains FIFO entries into a valid/stall stream for the next pipeline stage.
- Holds a 2-entry output register queue, so rdreq never depends combinationally on ds_stall.
- Sustains one transfer per clock when the FIFO is non-empty and downstream is not stalling.

---
 rtl/fifo_drain_vs.sv | 114 +++++++++++
 tb/tb_fifo_drain_vs.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_vs.sv
// fifo_drain_vs: drains a show-ahead FIFO into a valid/stall stream through a 2-entry output queue.
// Define FDRAIN_STATS_EN to add saturating xfer_cnt/stall_cnt statistics outputs.
module fifo_drain_vs #(
  parameter int WIDTH   = 8,
  parameter int STATS_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             empty,
  input  logic [WIDTH-1:0] fifo_data,
  output logic             rdreq,
  input  logic             flush,
  output logic             ds_valid,
  output logic [WIDTH-1:0] ds_data,
  input  logic             ds_stall
`ifdef FDRAIN_STATS_EN
  ,
  output logic [STATS_W-1:0] xfer_cnt,
  output logic [STATS_W-1:0] stall_cnt
`endif
);
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] e0_q, e0_d, e1_q, e1_d;
  logic push, pop;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= EMPTY;
      e0_q    <= '0;
      e1_q    <= '0;
    end else begin
      state_q <= state_d;
      e0_q    <= e0_d;
      e1_q    <= e1_d;
    end
  end
  always_comb begin
    state_d = state_q;
    e0_d    = e0_q;
    e1_d    = e1_q;
    if (flush) begin
      state_d = EMPTY;
      e0_d    = '0;
      e1_d    = '0;
    end else begin
      case (state_q)
        EMPTY: if (push) begin
          state_d = ONE;
          e0_d    = fifo_data;
        end
        ONE: if (push && pop) e0_d = fifo_data;
        else if (push) begin
          state_d = TWO;
          e1_d    = fifo_data;
        end else if (pop) begin
          state_d = EMPTY;
          e0_d    = '0;
        end
        TWO: if (pop) begin
          state_d = ONE;
          e0_d    = e1_q;
          e1_d    = '0;
        end
        default: state_d = EMPTY;
      endcase
    end
  end
  // rst gates rdreq so nothing is popped from the FIFO while reset is held
  always_comb begin
    rdreq    = rst && !empty && state_q != TWO && !flush;
    ds_valid = state_q != EMPTY;
    ds_data  = e0_q;
    push     = rdreq;
    pop      = ds_valid && !ds_stall;
  end
`ifdef FDRAIN_STATS_EN
  logic [STATS_W-1:0] xfer_q, xfer_d, stall_q, stall_d;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      xfer_q  <= '0;
      stall_q <= '0;
    end else begin
      xfer_q  <= xfer_d;
      stall_q <= stall_d;
    end
  end
  always_comb begin
    xfer_d  = flush ? '0 : (pop && !(&xfer_q)) ? xfer_q + STATS_W'(1) : xfer_q;
    stall_d = flush ? '0 : (ds_valid && ds_stall && !(&stall_q)) ? stall_q + STATS_W'(1) : stall_q;
  end
  assign xfer_cnt  = xfer_q;
  assign stall_cnt = stall_q;
`endif
`ifndef SYNTHESIS
  logic             hold_q;
  logic [WIDTH-1:0] held_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= 1'b0;
      held_q <= '0;
    end else begin
      hold_q <= ds_valid && ds_stall && !flush;
      held_q <= ds_data;
    end
  end
  always @(negedge clk) begin
    if (rst) begin
      assert (state_q != 2'd3) else $error("occupancy above two");
      assert (!(rdreq && empty)) else $error("rdreq while empty");
      assert (!hold_q || ds_data == held_q) else $error("ds_data moved under stall");
    end
  end
`endif
endmodule

// File: tb/tb_fifo_drain_vs.sv
// tb_fifo_drain_vs: directed vector table, hand sequences and a queue-level reference model for fifo_drain_vs.
module tb_fifo_drain_vs;
  localparam int SW = 4;
  logic clk = 0, rst = 0, empty = 1, flush = 0, ds_stall = 0;
  logic [7:0] fifo_data = '0, ds_data;
  logic rdreq, ds_valid;
`ifdef FDRAIN_STATS_EN
  logic [SW-1:0] xfer_cnt, stall_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  logic [7:0] fq[$], oq[$];
  int xc = 0, sc = 0;
  logic got_rd, got_v;
  logic [7:0] got_d;

  fifo_drain_vs #(.WIDTH(8), .STATS_W(SW)) dut (
    .clk(clk), .rst(rst), .empty(empty), .fifo_data(fifo_data), .rdreq(rdreq),
    .flush(flush), .ds_valid(ds_valid), .ds_data(ds_data), .ds_stall(ds_stall)
`ifdef FDRAIN_STATS_EN
    , .xfer_cnt(xfer_cnt), .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int npre;
    logic [7:0] p0, p1, p2;
    bit f, s, er, ev;
    logic [7:0] ed;
  } vec_t;
  vec_t tab[$];

  function automatic void add(int npre, logic [7:0] p0, p1, p2, bit f, s, er, ev, logic [7:0] ed);
    vec_t v;
    v.npre = npre; v.p0 = p0; v.p1 = p1; v.p2 = p2;
    v.f = f; v.s = s; v.er = er; v.ev = ev; v.ed = ed;
    tab.push_back(v);
  endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  // One clock: drive inputs, compare against the queue model at negedge, advance the model.
  task automatic cyc(input bit f, input bit s);
    bit er, ev, pop;
    logic [7:0] ed;
    flush = f;
    ds_stall = s;
    empty = (fq.size() == 0);
    fifo_data = empty ? 8'($urandom) : fq[0];
    @(negedge clk);
    ev = oq.size() != 0;
    ed = ev ? oq[0] : 8'h00;
    er = !empty && oq.size() < 2 && !f;
    got_rd = rdreq; got_v = ds_valid; got_d = ds_data;
    chk("rdreq", 32'(got_rd), 32'(er));
    chk("ds_valid", 32'(got_v), 32'(ev));
    chk("ds_data", 32'(got_d), 32'(ed));
`ifdef FDRAIN_STATS_EN
    chk("xfer_cnt", 32'(xfer_cnt), 32'(xc));
    chk("stall_cnt", 32'(stall_cnt), 32'(sc));
`endif
    pop = ev && !s;
    if (f) begin
      oq.delete();
      xc = 0; sc = 0;
    end else begin
      if (pop) void'(oq.pop_front());
      if (er) oq.push_back(fq.pop_front());
      if (pop && xc < (1 << SW) - 1) xc++;
      if (ev && s && sc < (1 << SW) - 1) sc++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    rst = 0;
    @(posedge clk);
    #1 rst = 1;
    oq.delete();
    xc = 0; sc = 0;
  endtask

  initial begin
    #2;
    chk("reset rdreq", 32'(rdreq), 0);
    chk("reset ds_valid", 32'(ds_valid), 0);
    chk("reset ds_data", 32'(ds_data), 0);
    @(posedge clk);
    #1 rst = 1;

    add(3, 8'h11, 8'h22, 8'h33, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 1, 1, 8'h11);
    add(0, 0, 0, 0, 0, 0, 1, 1, 8'h22);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'h33);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(3, 8'hA5, 8'hB6, 8'hC7, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 1, 1, 1, 8'hA5);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 0, 0, 1, 0, 1, 8'hA5);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'hA5);
    add(0, 0, 0, 0, 0, 0, 1, 1, 8'hB6);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'hC7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    add(3, 8'h01, 8'h02, 8'h03, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 1, 1, 1, 8'h01);
    add(0, 0, 0, 0, 0, 1, 0, 1, 8'h01);
    add(0, 0, 0, 0, 1, 1, 0, 1, 8'h01);
    add(0, 0, 0, 0, 0, 0, 1, 0, 8'h00);
    add(0, 0, 0, 0, 0, 0, 0, 1, 8'h03);
    add(0, 0, 0, 0, 0, 0, 0, 0, 8'h00);
    foreach (tab[i]) begin
      if (tab[i].npre > 0) fq.push_back(tab[i].p0);
      if (tab[i].npre > 1) fq.push_back(tab[i].p1);
      if (tab[i].npre > 2) fq.push_back(tab[i].p2);
      cyc(tab[i].f, tab[i].s);
      chk($sformatf("tab%0d rdreq", i), 32'(got_rd), 32'(tab[i].er));
      chk($sformatf("tab%0d valid", i), 32'(got_v), 32'(tab[i].ev));
      chk($sformatf("tab%0d data", i), 32'(got_d), 32'(tab[i].ed));
    end

    for (int i = 0; i < 8; i++) fq.push_back(8'h40 + 8'(i));
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0);
      chk("stream rdreq", 32'(got_rd), 32'(k < 8));
      chk("stream valid", 32'(got_v), 32'(k >= 1 && k <= 8));
      if (k >= 1 && k <= 8) chk("stream data", 32'(got_d), 32'(8'h40 + 8'(k - 1)));
    end

    fq.push_back(8'h71); fq.push_back(8'h72); fq.push_back(8'h73);
    cyc(0, 0);
    cyc(0, 1);
    empty = 0; fifo_data = fq[0]; ds_stall = 1;
    #1 chk("pre-reset valid", 32'(ds_valid), 1);
    #1 rst = 0;
    #1;
    chk("async rdreq", 32'(rdreq), 0);
    chk("async valid", 32'(ds_valid), 0);
    chk("async data", 32'(ds_data), 0);
    @(posedge clk);
    #1 rst = 1;
    oq.delete();
    xc = 0; sc = 0;
    cyc(0, 0);
    chk("restart rdreq", 32'(got_rd), 1);
    cyc(0, 0);
    chk("restart data", 32'(got_d), 32'(8'h73));
    cyc(0, 0);

`ifdef FDRAIN_STATS_EN
    reset_pulse();
    for (int i = 0; i < 20; i++) fq.push_back(8'h80 + 8'(i));
    for (int k = 0; k < 26; k++) cyc(0, k >= 5 && k <= 7);
    @(negedge clk);
    chk("xfer_cnt saturated", 32'(xfer_cnt), 15);
    chk("stall_cnt", 32'(stall_cnt), 3);
    cyc(1, 0);
    @(negedge clk);
    chk("xfer_cnt flushed", 32'(xfer_cnt), 0);
    chk("stall_cnt flushed", 32'(stall_cnt), 0);
    @(posedge clk);
    #1;
`endif

    reset_pulse();
    fq.delete();
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) < 6) fq.push_back(8'($urandom));
      cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
